// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter: frame-granular round-robin share of one uart_tx          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_FRAME  = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_en_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_FRAME + 1);
  localparam int STL_W = $clog2(TIMEOUT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [STL_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                 timeout_q, timeout_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W:0]       cand;
  logic [IDX_W-1:0]     next_ptr;
  logic                 g_valid;
  logic                 g_last;
  logic                 beat;
  logic                 rel;

  // Rotating priority search starting at rr_ptr; one extra bit absorbs the wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign g_valid  = req_valid_i[gidx_q];
  assign g_last   = req_last_i[gidx_q];
  assign beat     = (state_q == LOCK) && g_valid && tx_ready_i;
  assign next_ptr = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    if (state_q == LOCK) begin
      tx_valid_o          = g_valid;
      tx_data_o           = req_data_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];
      req_ready_o[gidx_q] = tx_ready_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = 1'b0;
    rel         = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_en_i && win_found) begin
          state_d     = LOCK;
          gidx_d      = win_idx;
          grant_d     = NUM_REQ'(1) << win_idx;
          byte_cnt_d  = '0;
          stall_cnt_d = '0;
        end
      end
      LOCK: begin
        // Back-pressure with valid high is not a stall.
        stall_cnt_d = g_valid ? '0 : stall_cnt_q + STL_W'(1);
        if (beat) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (g_last || (byte_cnt_q == CNT_W'(MAX_FRAME - 1))) begin
            rel = 1'b1;
          end
        end else if (!g_valid && (stall_cnt_q == STL_W'(TIMEOUT - 1))) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end
        if (rel) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q == LOCK);
  assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_arbiter: randomized scoreboard bench for uart_tx_arbiter       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MF = 8;
  localparam int TO = 16;

  logic              clk;
  logic              rst;
  logic              cfg_en_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR*DW-1:0]  req_data_i;
  logic [NR-1:0]     req_last_i;
  logic [NR-1:0]     req_ready_o;
  logic [DW-1:0]     tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic [NR-1:0]     grant_o;
  logic              busy_o;
  logic              timeout_o;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_FRAME  (MF),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_en_i    (cfg_en_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus knobs, set by the main sequence.
  bit stim_en  = 1'b0;
  int last_pct = 30;
  int long_pct = 5;
  int rdy_pct  = 60;

  // Scoreboard: bytes each requester has offered, in order, as {last, data}.
  logic [DW:0] exp_q [NR][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver: requester sources and uart_tx ready ----------------
  logic [NR-1:0] acc_s;
  int            gap [NR];

  initial begin : driver
    logic [DW-1:0] d;
    logic          l;
    for (int i = 0; i < NR; i++) gap[i] = 0;
    forever begin
      @(negedge clk);
      acc_s = req_valid_i & req_ready_o;
      @(posedge clk);
      #1;
      if (!rst) begin
        req_valid_i = '0;
        req_last_i  = '0;
        for (int i = 0; i < NR; i++) begin
          exp_q[i].delete();
          gap[i] = 0;
        end
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (acc_s[i]) begin
            req_valid_i[i] = 1'b0;
            gap[i] = ($urandom_range(0, 99) < long_pct) ? 20 : $urandom_range(0, 2);
          end
          if (!req_valid_i[i]) begin
            if (gap[i] > 0) begin
              gap[i]--;
            end else if (stim_en && $urandom_range(0, 99) < 70) begin
              d = DW'($urandom);
              l = ($urandom_range(0, 99) < last_pct);
              req_data_i[i*DW +: DW] = d;
              req_last_i[i]          = l;
              req_valid_i[i]         = 1'b1;
              exp_q[i].push_back({l, d});
            end
          end
        end
        tx_ready_i = ($urandom_range(0, 99) < rdy_pct);
      end
    end
  end

  // ---------------- monitor: frame-level reference model + scoreboard ----------------
  int          owner  = -1;
  int          ptr    = 0;
  int          nbytes = 0;
  int          stall  = 0;
  bit          exp_to = 1'b0;

  initial begin : monitor
    int          nowner;
    bit          nto;
    bit          v;
    int          idx;
    logic [31:0] ge;
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        owner  = -1;
        ptr    = 0;
        exp_to = 1'b0;
      end else begin
        nowner = owner;
        nto    = 1'b0;
        ge     = (owner < 0) ? 32'd0 : (32'd1 << owner);
        chk("grant", 32'(grant_o), ge);
        chk("busy", 32'(busy_o), 32'(owner >= 0));
        chk("timeout_pulse", 32'(timeout_o), 32'(exp_to));
        if (owner < 0) begin
          chk("idle_tx_valid", 32'(tx_valid_o), 32'd0);
          chk("idle_ready", 32'(req_ready_o), 32'd0);
          chk("idle_tx_data", 32'(tx_data_o), 32'd0);
          if (cfg_en_i) begin
            for (int k = 0; k < NR; k++) begin
              idx = (ptr + k) % NR;
              if (nowner < 0 && req_valid_i[idx]) nowner = idx;
            end
            nbytes = 0;
            stall  = 0;
          end
        end else begin
          v = req_valid_i[owner];
          chk("tx_valid", 32'(tx_valid_o), 32'(v));
          chk("ready", 32'(req_ready_o), tx_ready_i ? (32'd1 << owner) : 32'd0);
          if (v) chk("fwd_data", 32'(tx_data_o), 32'(req_data_i[owner*DW +: DW]));
          if (v && tx_ready_i) begin
            if (exp_q[owner].size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL beat_sb: requester %0d beat with empty scoreboard, got %0h", owner, tx_data_o);
            end else begin
              e = exp_q[owner].pop_front();
              chk("beat_data", 32'(tx_data_o), 32'(e[DW-1:0]));
            end
            nbytes++;
            stall = 0;
            if (req_last_i[owner] || nbytes == MF) begin
              nowner = -1;
              ptr    = (owner + 1) % NR;
            end
          end else if (!v) begin
            stall++;
            if (stall == TO) begin
              nowner = -1;
              ptr    = (owner + 1) % NR;
              nto    = 1'b1;
            end
          end else begin
            stall = 0;
          end
        end
        owner  = nowner;
        exp_to = nto;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    bit found;
    rst         = 1'b0;
    cfg_en_i    = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    tx_ready_i  = 1'b0;
    #1;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    stim_en = 1'b1;

    // Mixed traffic with slow uart_tx.
    last_pct = 30; long_pct = 5; rdy_pct = 25;
    repeat (1500) @(posedge clk);
    // Endless frames: every release is a MAX_FRAME cut.
    last_pct = 0; long_pct = 0; rdy_pct = 90;
    repeat (400) @(posedge clk);
    // Long source gaps provoke timeouts.
    last_pct = 20; long_pct = 30; rdy_pct = 70;
    repeat (800) @(posedge clk);
    // Enable toggling at random points.
    last_pct = 25; long_pct = 3; rdy_pct = 60;
    repeat (600) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 19) == 0) cfg_en_i = ~cfg_en_i;
    end
    @(posedge clk);
    #1 cfg_en_i = 1'b1;

    // Asynchronous reset in the middle of an active beat.
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (busy_o && tx_valid_o) found = 1'b1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL async_rst_setup: got no active beat in 500 cycles, expected one");
    end else begin
      #2 rst = 1'b0;
      #1;
      chk("async_grant", 32'(grant_o), 32'd0);
      chk("async_busy", 32'(busy_o), 32'd0);
      chk("async_tx_valid", 32'(tx_valid_o), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
    end
    last_pct = 30; long_pct = 5; rdy_pct = 50;
    repeat (300) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
